// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - IF stage: PC capture, imem req/ack read, IF/ID register with skid
//
// Runs one instruction-memory read per fetch. It captures the PC from the address
// generator, requests the word, and loads the IF/ID register. It also drives the
// generator's stall, so the PC moves only on acceptance or redirect.
//
// Parameters:
//   NOP_INSTR       bubble loaded into if_id_instr when IF/ID holds no instruction
//   TIMEOUT_CYCLES  max unacknowledged REQ/DROP cycles before a fault (FETCH_TIMEOUT_EN only)
//
// Optional feature macro: FETCH_TIMEOUT_EN (adds the request timeout and the fetch_fault port)
//
// Ports:
//   clk          in   clock, all state updates on posedge
//   rst          in   synchronous reset, active-low
//   pc_in        in   [31:0] current PC from the address generator
//   fetch_stall  out  address generator stall; 0 lets the PC update this edge
//   flush        in   one-cycle redirect pulse, coincident with the PC redirect
//   imem_req     out  read request, held until imem_ack
//   imem_addr    out  [31:0] read address, stable while imem_req is high
//   imem_ack     in   one-cycle acknowledge; imem_rdata valid in the same cycle
//   imem_rdata   in   [31:0] instruction word
//   stall_id     in   decode cannot accept; IF/ID must hold
//   fetch_fault  out  one-cycle timeout pulse (FETCH_TIMEOUT_EN only)
//   if_id_valid  out  IF/ID holds a real instruction
//   if_id_instr  out  [31:0] fetched instruction (NOP_INSTR when invalid)
//   if_id_pc     out  [31:0] PC of if_id_instr

module instruction_fetch_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
`ifdef FETCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        fetch_stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_id,
`ifdef FETCH_TIMEOUT_EN
  output logic        fetch_fault,
`endif
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] addr_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_pc_q;
  logic        slot_free;
  logic        timeout;

  assign imem_req  = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem_addr = addr_q;
  assign slot_free = !if_id_valid || !stall_id;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign timeout = imem_req && !imem_ack && (cnt == CNT_LAST);

  // The counter restarts whenever the state changes or no request is open, so
  // it always counts waiting cycles of the current REQ/DROP visit only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      fetch_fault <= 1'b0;
    end else begin
      fetch_fault <= timeout && !flush;
      if ((state_d != state_q) || !imem_req || imem_ack) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next state and generator stall. A flush always releases the PC; otherwise
  // the PC only moves when this stage hands an instruction to IF/ID.
  always_comb begin
    state_d     = state_q;
    fetch_stall = 1'b1;
    if (flush) begin
      fetch_stall = 1'b0;
      case (state_q)
        // An open request must still see its ack before a new one can issue.
        S_REQ:   state_d = imem_ack ? S_LOAD : S_DROP;
        S_DROP:  state_d = imem_ack ? S_LOAD : S_DROP;
        default: state_d = S_LOAD;
      endcase
    end else begin
      case (state_q)
        S_LOAD: state_d = S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            state_d     = slot_free ? S_LOAD : S_HOLD;
            fetch_stall = !slot_free;
          end else if (timeout) begin
            state_d = S_LOAD;
          end
        end
        S_HOLD: begin
          if (!stall_id) begin
            state_d     = S_LOAD;
            fetch_stall = 1'b0;
          end
        end
        S_DROP: begin
          if (imem_ack || timeout) begin
            state_d = S_LOAD;
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_LOAD;
      addr_q       <= '0;
      if_id_valid  <= 1'b0;
      if_id_instr  <= NOP_INSTR;
      if_id_pc     <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
    end else begin
      state_q <= state_d;

      // The PC is redirected on a flush edge, so capturing it then would be stale.
      if ((state_q == S_LOAD) && !flush) begin
        addr_q <= pc_in;
      end

      if (flush) begin
        if_id_valid  <= 1'b0;
        if_id_instr  <= NOP_INSTR;
        skid_instr_q <= NOP_INSTR;
        skid_pc_q    <= '0;
      end else if ((state_q == S_REQ) && imem_ack && slot_free) begin
        if_id_valid <= 1'b1;
        if_id_instr <= imem_rdata;
        if_id_pc    <= addr_q;
      end else if ((state_q == S_HOLD) && !stall_id) begin
        if_id_valid <= 1'b1;
        if_id_instr <= skid_instr_q;
        if_id_pc    <= skid_pc_q;
      end else begin
        if (!stall_id) begin
          if_id_valid <= 1'b0;
          if_id_instr <= NOP_INSTR;
        end
        // Decode is blocked, so the returning word parks in the skid entry.
        if ((state_q == S_REQ) && imem_ack) begin
          skid_instr_q <= imem_rdata;
          skid_pc_q    <= addr_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - directed self-checking bench for instruction_fetch_stage

module tb_instruction_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        fetch_stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall_id;
`ifdef FETCH_TIMEOUT_EN
  logic        fetch_fault;
`endif
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;

  int compared;
  int mismatched;

  instruction_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .fetch_stall (fetch_stall),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall_id    (stall_id),
`ifdef FETCH_TIMEOUT_EN
    .fetch_fault (fetch_fault),
`endif
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled mid-low-phase.
  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;
    flush      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    stall_id   = 1'b0;
    pc_in      = 32'h0;

    // T1 reset
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("t1_valid", if_id_valid, 1'b0);
    chk("t1_instr", if_id_instr, 32'h13);
    chk("t1_req", imem_req, 1'b0);
    chk("t1_stall", fetch_stall, 1'b1);
    chk("t1_addr", imem_addr, 32'h0);
    rst = 1'b1;

    // T2 stream: LOAD then REQ at 0x0, ack immediately
    nxt();
    chk("t2_req", imem_req, 1'b1);
    chk("t2_addr0", imem_addr, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hA;
    #1;
    chk("t2_stall_on_ack", fetch_stall, 1'b0);
    nxt();
    imem_ack = 1'b0;
    pc_in    = 32'h4;
    #1;
    chk("t2_valid", if_id_valid, 1'b1);
    chk("t2_instr", if_id_instr, 32'hA);
    chk("t2_pc", if_id_pc, 32'h0);
    chk("t2_stall_load", fetch_stall, 1'b1);
    chk("t2_req_load", imem_req, 1'b0);
    nxt();
    chk("t2_addr4", imem_addr, 32'h4);
    chk("t2_req4", imem_req, 1'b1);
    chk("t2_bubble", if_id_valid, 1'b0);
    chk("t2_stall_noack", fetch_stall, 1'b1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h44;
    #1;
    chk("t2_stall_ack4", fetch_stall, 1'b0);

    // T3 back-pressure with a valid IF/ID
    nxt();
    imem_ack = 1'b0;
    pc_in    = 32'h8;
    stall_id = 1'b1;
    nxt();
    chk("t3_addr8", imem_addr, 32'h8);
    imem_ack   = 1'b1;
    imem_rdata = 32'hB;
    #1;
    chk("t3_stall_full", fetch_stall, 1'b1);
    nxt();
    imem_ack = 1'b0;
    #1;
    chk("t3_hold_req", imem_req, 1'b0);
    chk("t3_hold_valid", if_id_valid, 1'b1);
    chk("t3_hold_instr", if_id_instr, 32'h44);
    chk("t3_hold_pc", if_id_pc, 32'h4);
    chk("t3_hold_stall", fetch_stall, 1'b1);
    nxt();
    chk("t3_hold2_instr", if_id_instr, 32'h44);
    stall_id = 1'b0;
    #1;
    chk("t3_release_stall", fetch_stall, 1'b0);
    nxt();
    pc_in    = 32'hC;
    stall_id = 1'b1;
    #1;
    chk("t3_valid", if_id_valid, 1'b1);
    chk("t3_instr", if_id_instr, 32'hB);
    chk("t3_pc", if_id_pc, 32'h8);

    // T4 flush in REQ without ack, IF/ID valid and held by stall_id
    nxt();
    chk("t4_addrC", imem_addr, 32'hC);
    chk("t4_held_valid", if_id_valid, 1'b1);
    flush = 1'b1;
    #1;
    chk("t4_flush_stall", fetch_stall, 1'b0);
    nxt();
    flush    = 1'b0;
    stall_id = 1'b0;
    pc_in    = 32'h100;
    #1;
    chk("t4_valid", if_id_valid, 1'b0);
    chk("t4_instr", if_id_instr, 32'h13);
    chk("t4_drop_req", imem_req, 1'b1);
    chk("t4_drop_addr", imem_addr, 32'hC);
    chk("t4_drop_stall", fetch_stall, 1'b1);
    nxt();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD;
    #1;
    chk("t4_late_ack_stall", fetch_stall, 1'b1);
    nxt();
    imem_ack = 1'b0;
    #1;
    chk("t4_discard_valid", if_id_valid, 1'b0);
    chk("t4_discard_instr", if_id_instr, 32'h13);
    chk("t4_load_req", imem_req, 1'b0);
    nxt();
    chk("t4_new_addr", imem_addr, 32'h100);
    chk("t4_new_req", imem_req, 1'b1);

    // T5 flush coincident with ack
    flush      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD;
    #1;
    chk("t5_flush_stall", fetch_stall, 1'b0);
    nxt();
    flush    = 1'b0;
    imem_ack = 1'b0;
    pc_in    = 32'h200;
    #1;
    chk("t5_valid", if_id_valid, 1'b0);
    chk("t5_instr", if_id_instr, 32'h13);
    nxt();
    chk("t5_addr", imem_addr, 32'h200);
    imem_ack   = 1'b1;
    imem_rdata = 32'h77;
    nxt();
    imem_ack = 1'b0;
    pc_in    = 32'h204;
    #1;
    chk("t5_next_valid", if_id_valid, 1'b1);
    chk("t5_next_instr", if_id_instr, 32'h77);
    chk("t5_next_pc", if_id_pc, 32'h200);

    // Reset mid-request, then a late ack
    nxt();
    chk("rst_pre_req", imem_req, 1'b1);
    rst = 1'b0;
    nxt();
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hEE;
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_stall", fetch_stall, 1'b1);
    chk("rst_valid", if_id_valid, 1'b0);
    nxt();
    imem_ack = 1'b0;
    #1;
    chk("rst_late_valid", if_id_valid, 1'b0);
    chk("rst_late_instr", if_id_instr, 32'h13);
    chk("rst_retry_addr", imem_addr, 32'h204);
    chk("rst_retry_req", imem_req, 1'b1);

`ifdef FETCH_TIMEOUT_EN
    // T6 sixteen unacknowledged request cycles then a fault pulse
    for (int i = 0; i < 16; i++) begin
      chk("t6_wait_req", imem_req, 1'b1);
      chk("t6_wait_fault", fetch_fault, 1'b0);
      nxt();
    end
    chk("t6_fault", fetch_fault, 1'b1);
    chk("t6_req_drop", imem_req, 1'b0);
    nxt();
    chk("t6_fault_clear", fetch_fault, 1'b0);
    chk("t6_retry_req", imem_req, 1'b1);
    chk("t6_retry_addr", imem_addr, 32'h204);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
